spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
- Synthesizable SPI slave receiver. Counterpart of the team's SPI DAC master driver.
- Captures MSB-first frames from cs_n/sclk/mosi, sampling mosi on the sclk rising edge. Timing: sclk idles high, data changes on the falling edge, cs_n frames the transfer.
- Presents each valid frame as one AXI-stream word.
- Used in the FPGA loopback/self-test path and as a synthesizable stand-in for the DAC in board bring-up.

Parameters:
- DATA_WIDTH, 16, bits per frame and width of m_axis_data.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).

Ports:
- mclk  input  1  system clock, 50 MHz; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cs_n  input  1  SPI chip select, active low, asynchronous to mclk.
- sclk  input  1  SPI clock, idles high, ≤ mclk/8.
- mosi  input  1  SPI serial data, MSB first.
- m_axis_valid  output  1  received word available.
- m_axis_data  output  DATA_WIDTH  received word.
- s_axis_ready  input  1  downstream accepts word.
- frame_err  output  1  one-cycle pulse: frame ended with bit count ≠ DATA_WIDTH.
- overflow  output  1  one-cycle pulse: good frame dropped because the output word was still held.
- frame_cnt  output  16  count of good frames delivered to the output register; wraps 0xFFFF→0.

Behaviour:
- Reset values:
  - m_axis_valid=0, m_axis_data=0, frame_err=0, overflow=0, frame_cnt=0.
  - Synchronizer flops reset to idle levels: cs_n=1, sclk=1, mosi=0.
  - Shift register and bit counter = 0.
  - State = WAIT_HIGH.
- Input conditioning:
  - cs_n, sclk and mosi each pass through SYNC_STAGES flops, giving cs_s, sclk_s, mosi_s with equal delay so their relative timing is preserved.
  - One further register on cs_s and sclk_s yields edge detects: sclk_rise, cs_fall, cs_rise.
- State machine:
  - WAIT_HIGH: entered from reset. Moves to IDLE once cs_s==1. Prevents capturing a partial frame when reset releases mid-transfer.
  - IDLE: on cs_fall, clear shift register and bit counter, then go to RECV.
  - RECV: on each sclk_rise, shift left with mosi_s into the LSB and increment the bit counter. The counter saturates at DATA_WIDTH+1. On cs_rise go to END; the cs_rise cycle's sclk_rise, if coincident, is ignored.
  - END (one cycle): evaluate the frame, then go to IDLE.
- Frame evaluation in END:
  - Bit count == DATA_WIDTH (good frame):
    - If m_axis_valid==0, or m_axis_valid==1 && s_axis_ready==1 in this cycle: load m_axis_data, set m_axis_valid=1, increment frame_cnt.
    - Otherwise: keep the old word, pulse overflow, leave frame_cnt unchanged.
  - Bit count ≠ DATA_WIDTH (short, or long including saturated): pulse frame_err; output register untouched.
  - Zero-bit frame (cs_n low then high with no clocks) is an error.
- sclk rising edges while cs_s==1 are ignored in every state.
- AXI output:
  - m_axis_valid stays high until the cycle in which s_axis_ready==1, then drops the next cycle unless END reloads it in that same cycle.
  - m_axis_data is stable while valid && !ready.
- Latency: the word is visible SYNC_STAGES+2 mclk cycles after the first mclk edge that samples cs_n high (SYNC_STAGES sync, 1 edge detect, 1 END).
- Reset mid-frame: all state is discarded, no pulses are emitted, and the block returns to WAIT_HIGH.
- Minimum inter-frame cs_n high time: 3 mclk cycles. Shorter gaps are outside the specified operating range.

Decomposition:
- Package spi_pkg:
  - rx_state_e enum {WAIT_HIGH, IDLE, RECV, END}.
  - SPI_DATA_WIDTH=16.
  - MCLK_CYCLES_PER_SPI_CLK_CYCLE=8, shared with the DAC driver.
- One sub-module, bit_sync: a parameterized SYNC_STAGES flop synchronizer with a reset value parameter. Instantiated three times.

Test Plan:
- Reset, then frame 0xA5C3 sent with the DAC driver timing (sclk=mclk/8), ready held 1 → one valid beat with data=0xA5C3, frame_cnt=1, no frame_err or overflow.
- Frames 0x0001, 0x8000, 0xFFFF back-to-back with a 3-cycle cs_n gap, ready=1 → three beats in order, frame_cnt=3.
- 15-bit frame, then a 17-bit frame → two frame_err pulses, m_axis_valid stays 0, frame_cnt=0. A following 0x1234 frame is received correctly.
- ready held 0; send 0x1111 then 0x2222 → data stays 0x1111 with valid high, one overflow pulse. Raising ready → single beat 0x1111, then valid=0.
- Assert rst after 8 bits of a frame while cs_n is still low; release rst with cs_n still low and finish the clocks → no output and no pulses. The next full frame 0xBEEF is received.
- frame_cnt preloaded by forcing it to 0xFFFF, then one good frame → frame_cnt=0x0000.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the DAC driver and the slave receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    RECV,
    END
  } rx_state_e;

  localparam int SPI_DATA_WIDTH                = 16;
  localparam int MCLK_CYCLES_PER_SPI_CLK_CYCLE = 8;

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flop synchronizer for one asynchronous input bit, with a
// configurable reset level.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic mclk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge mclk) begin
    if (rst) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: captures MSB-first frames framed by cs_n and presents
// each complete frame as one AXI-stream word.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  s_axis_ready,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [15:0]           frame_cnt
);

  localparam int CNT_W   = $clog2(DATA_WIDTH + 2);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(DATA_WIDTH + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);
  // Idle levels per input, bit order {mosi, sclk, cs_n}.
  localparam logic [2:0] SYNC_RST = 3'b011;

  logic [2:0] raw_in;
  logic [2:0] sync_out;
  logic       cs_s, sclk_s, mosi_s;

  assign raw_in = {mosi, sclk, cs_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      bit_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_RST[gi])
      ) u_bit_sync (
        .mclk (mclk),
        .rst  (rst),
        .d    (raw_in[gi]),
        .q    (sync_out[gi])
      );
    end
  endgenerate

  assign cs_s   = sync_out[0];
  assign sclk_s = sync_out[1];
  assign mosi_s = sync_out[2];

  logic cs_d_reg, sclk_d_reg;
  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_rise = sclk_s & ~sclk_d_reg & ~cs_s;
  assign cs_fall   = ~cs_s & cs_d_reg;
  assign cs_rise   = cs_s & ~cs_d_reg;

  rx_state_e             state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [FLUSH_W-1:0]    flush_reg, flush_next;
  logic                  valid_reg, valid_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic [15:0]           frame_cnt_reg, frame_cnt_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  overflow_reg, overflow_next;

  always_ff @(posedge mclk) begin
    if (rst) begin
      cs_d_reg      <= 1'b1;
      sclk_d_reg    <= 1'b1;
      state_reg     <= WAIT_HIGH;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      flush_reg     <= '0;
      valid_reg     <= 1'b0;
      data_reg      <= '0;
      frame_cnt_reg <= '0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      cs_d_reg      <= cs_s;
      sclk_d_reg    <= sclk_s;
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      flush_reg     <= flush_next;
      valid_reg     <= valid_next;
      data_reg      <= data_next;
      frame_cnt_reg <= frame_cnt_next;
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    flush_next     = flush_reg;
    valid_next     = valid_reg & ~s_axis_ready;
    data_next      = data_reg;
    frame_cnt_next = frame_cnt_reg;
    frame_err_next = 1'b0;
    overflow_next  = 1'b0;
    case (state_reg)
      // The synchronizers restart at idle levels, so cs_s only reflects the
      // pin once they have refilled; judge cs_s only after that.
      WAIT_HIGH: begin
        if (flush_reg != FLUSH_DONE) begin
          flush_next = flush_reg + FLUSH_W'(1);
        end else if (cs_s) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          shift_next = '0;
          cnt_next   = '0;
          state_next = RECV;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_next = END;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[DATA_WIDTH-2:0], mosi_s};
          if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      END: begin
        state_next = IDLE;
        if (cnt_reg == CNT_FULL) begin
          if (!valid_reg || s_axis_ready) begin
            data_next      = shift_reg;
            valid_next     = 1'b1;
            frame_cnt_next = frame_cnt_reg + 16'd1;
          end else begin
            overflow_next = 1'b1;
          end
        end else begin
          frame_err_next = 1'b1;
        end
      end
      default: state_next = WAIT_HIGH;
    endcase
  end

  assign m_axis_valid = valid_reg;
  assign m_axis_data  = data_reg;
  assign frame_cnt    = frame_cnt_reg;
  assign frame_err    = frame_err_reg;
  assign overflow     = overflow_reg;

endmodule
